// File: rtl/serial_word_capture.sv
// -----------------------------------------------------------------------------
// serial_word_capture
//
// Collects the serial bit stream of the inverting net-delay shift path into
// WIDTH-bit words, MSB first. A word starts on a bit marked by `sof`. Each
// completed word is offered on a single-entry valid/ready output register.
//
// Optional feature (macro SERIAL_WORD_CAPTURE_PARITY_EN):
//   defined   - each frame is WIDTH data bits plus one even-parity bit. The
//               parity bit is checked but not stored. `par_err` flags a
//               mismatch for the word held in `y`.
//   undefined - frames are exactly WIDTH bits and `par_err` stays 0.
//
// Handshake: `y` is offered while `y_valid` is high. It is transferred on a
// rising edge where `y_valid && y_ready`. `y` and `par_err` stay stable until
// that transfer. If a word completes while the register is full and is not
// being drained, the new word is dropped and `overrun` is set.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   x            in   serial data bit
//   x_valid      in   x is sampled this edge
//   sof          in   x is the first bit of a word (qualified by x_valid)
//   y            out  assembled word; first bit received sits in y[WIDTH-1]
//   y_valid      out  y holds an unconsumed word
//   y_ready      in   consumer accepts y
//   par_err      out  parity mismatch for the word in y
//   overrun      out  sticky, a completed word was dropped
//   ovr_clr      in   clears overrun (a simultaneous overrun wins)
//   dbg_state_o  out  current FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module serial_word_capture #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             par_err,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             dbg_state_o
);

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  // The counter must hold N without wrapping.
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             par_err_q, par_err_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sh_shifted;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             take;

  assign sh_shifted = {sh_q[WIDTH-2:0], x};

  // The word and its parity status as they stand when the final bit arrives.
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
  // The final bit is the parity bit, so the data bits are already in sh_q.
  assign word      = sh_q;
  assign word_perr = (^sh_q) ^ x;
`else
  assign word      = sh_shifted;
  assign word_perr = 1'b0;
`endif

  // Framing FSM: next state, counter and shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (x_valid && sof) begin
          sh_d    = sh_shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (x_valid) begin
          if (sof) begin
            // A new frame start abandons the partial word.
            sh_d  = sh_shifted;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
`ifndef SERIAL_WORD_CAPTURE_PARITY_EN
            sh_d     = sh_shifted;
`endif
          end else begin
            sh_d  = sh_shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: a completed word loads if the register is empty or is
  // being drained on this edge. Otherwise the word is lost.
  assign take = !y_valid_q || y_ready;

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    par_err_d = par_err_q;
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (complete && take) begin
      y_d       = word;
      y_valid_d = 1'b1;
      par_err_d = word_perr;
    end else begin
      if (complete) begin
        overrun_d = 1'b1;
      end
      if (y_valid_q && y_ready) begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      par_err_q <= par_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign y           = y_q;
  assign y_valid     = y_valid_q;
  assign par_err     = par_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_word_capture.sv
module tb_serial_word_capture;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             x;
  logic             x_valid;
  logic             sof;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             par_err;
  logic             overrun;
  logic             ovr_clr;
  logic             dbg_state;

  int total = 0;
  int bad   = 0;

  serial_word_capture #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .x_valid     (x_valid),
    .sof         (sof),
    .y           (y),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .par_err     (par_err),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparison helper
  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic idle_cycle();
    @(negedge clk);
    x_valid = 1'b0;
    sof     = 1'b0;
    x       = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    x       = b;
    x_valid = 1'b1;
    sof     = s;
  endtask

  // Sends WIDTH data bits MSB first (sof on the first), then the parity bit
  // when parity is built in. rdy_last raises y_ready with the final bit.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic pb,
                            input bit gaps, input bit rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
      send_bit(w[i], i == WIDTH - 1);
`ifndef SERIAL_WORD_CAPTURE_PARITY_EN
      if (i == 0 && rdy_last) y_ready = 1'b1;
`endif
    end
`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
    send_bit(pb, 1'b0);
    if (rdy_last) y_ready = 1'b1;
`else
    if (pb === 1'bz) $display("unreachable");
`endif
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps, input bit rdy_last);
    send_frame(w, ^w, gaps, rdy_last);
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; x_valid = 1'b0; sof = 1'b0;
    y_ready = 1'b1; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_y", y, '0);
    chk("reset_y_valid", WIDTH'(y_valid), '0);
    chk("reset_par_err", WIDTH'(par_err), '0);
    chk("reset_overrun", WIDTH'(overrun), '0);
    chk("reset_state", WIDTH'(dbg_state), '0);
    rst = 1'b0;

    // Basic word
    send_word(32'hA5A50F0F, 1'b0, 1'b0);
    idle_cycle();
    chk("basic_valid", WIDTH'(y_valid), 1);
    chk("basic_y", y, 32'hA5A50F0F);
    chk("basic_par", WIDTH'(par_err), 0);
    chk("basic_state_idle", WIDTH'(dbg_state), 0);
    idle_cycle();
    chk("basic_valid_drop", WIDTH'(y_valid), 0);

    // Backpressure and overrun
    y_ready = 1'b0;
    send_word(32'h12345678, 1'b0, 1'b0);
    idle_cycle();
    chk("bp_first_valid", WIDTH'(y_valid), 1);
    chk("bp_first_y", y, 32'h12345678);
    chk("bp_first_ovr", WIDTH'(overrun), 0);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    idle_cycle();
    chk("bp_hold_y", y, 32'h12345678);
    chk("bp_hold_valid", WIDTH'(y_valid), 1);
    chk("bp_overrun", WIDTH'(overrun), 1);
    y_ready = 1'b1;
    idle_cycle();
    chk("bp_accept_valid", WIDTH'(y_valid), 0);
    chk("bp_overrun_sticky", WIDTH'(overrun), 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("bp_ovr_clr", WIDTH'(overrun), 0);

    // Accept on the same edge the next word completes
    y_ready = 1'b0;
    send_word(32'h11111111, 1'b0, 1'b0);
    idle_cycle();
    chk("sim_first_y", y, 32'h11111111);
    send_word(32'h22222222, 1'b0, 1'b1);
    idle_cycle();
    chk("sim_y", y, 32'h22222222);
    chk("sim_valid", WIDTH'(y_valid), 1);
    chk("sim_overrun", WIDTH'(overrun), 0);
    idle_cycle();
    chk("sim_drain", WIDTH'(y_valid), 0);

    // Mid-word restart with gaps
    for (int i = 0; i < 10; i++) send_bit(1'(i % 2), i == 0);
    send_word(32'hFFFF0000, 1'b1, 1'b0);
    idle_cycle();
    chk("restart_y", y, 32'hFFFF0000);
    chk("restart_valid", WIDTH'(y_valid), 1);
    chk("restart_ovr", WIDTH'(overrun), 0);
    idle_cycle();
    // Bits without sof in IDLE
    for (int i = 0; i < 40; i++) send_bit(1'b1, 1'b0);
    idle_cycle();
    chk("nosof_valid", WIDTH'(y_valid), 0);
    chk("nosof_state", WIDTH'(dbg_state), 0);
    chk("nosof_y", y, 32'hFFFF0000);

    // Reset mid-word
    for (int i = 0; i < 16; i++) send_bit(1'b1, i == 0);
    @(negedge clk); x_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_state", WIDTH'(dbg_state), 0);
    chk("rst_mid_y", y, '0);
    @(negedge clk); rst = 1'b0;
    // Reset while holding a word
    y_ready = 1'b0;
    send_word(32'h0BADF00D, 1'b0, 1'b0);
    idle_cycle();
    chk("rst_hold_valid_pre", WIDTH'(y_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_y", y, '0);
    chk("rst_hold_valid", WIDTH'(y_valid), 0);
    chk("rst_hold_ovr", WIDTH'(overrun), 0);
    @(negedge clk); rst = 1'b0; y_ready = 1'b1;
    send_word(32'hCAFEBABE, 1'b0, 1'b0);
    idle_cycle();
    chk("post_rst_y", y, 32'hCAFEBABE);
    chk("post_rst_valid", WIDTH'(y_valid), 1);

`ifdef SERIAL_WORD_CAPTURE_PARITY_EN
    send_frame(32'h00000001, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    chk("par_good_y", y, 32'h00000001);
    chk("par_good_err", WIDTH'(par_err), 0);
    send_frame(32'h00000001, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    chk("par_bad_y", y, 32'h00000001);
    chk("par_bad_err", WIDTH'(par_err), 1);
`endif

    repeat (2) idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
